// File: rtl/seg_scan_ctrl_pkg.sv
// seg_pkg: shared display constants and types.
//   HEX7SEG   - nibble -> 7 active-low segment bits {G,F,E,D,C,B,A}
//   SEG_OFF   - cathode bus value with everything dark
//   AN_OFF    - anode bus value with every digit off
//   dig_t     - digit index (0 = rightmost)
//   disp_buf_t- one display buffer (value, decimal points, forced blanks)
//   lzb_off() - leading-zero test for a digit slot
package seg_pkg;

  typedef logic [1:0] dig_t;

  typedef struct packed {
    logic [15:0] value;
    logic [3:0]  dp;
    logic [3:0]  blank;
  } disp_buf_t;

  localparam logic [7:0] SEG_OFF = 8'hFF;
  localparam logic [3:0] AN_OFF  = 4'hF;

  localparam logic [6:0] HEX7SEG [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  // True when digit d is a leading zero: every nibble at d and above is 0.
  // Digit 0 always shows, so a lone zero stays visible.
  function automatic logic lzb_off(input logic [15:0] v, input dig_t d);
    case (d)
      2'd1:    return (v[15:4]  == 12'h000);
      2'd2:    return (v[15:8]  == 8'h00);
      2'd3:    return (v[15:12] == 4'h0);
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// Display bus between the datapath (master) and seg_scan_ctrl (slave).
//   en, load, value, dp, blank : master -> slave data/control
//   seg, an, frame             : slave -> master / pins
interface seg_scan_ctrl_if;
  logic        en;
  logic        load;
  logic [15:0] value;
  logic [3:0]  dp;
  logic [3:0]  blank;
  logic [7:0]  seg;
  logic [3:0]  an;
  logic        frame;

  modport master (output en, load, value, dp, blank, input  seg, an, frame);
  modport slave  (input  en, load, value, dp, blank, output seg, an, frame);
endinterface

// File: rtl/seg_scan_ctrl_hex7seg.sv
// hex7seg: combinational hex nibble -> active-low 7-segment decoder.
//   i_nib  hex digit
//   o_seg  {G,F,E,D,C,B,A}, 0 = segment lit
module hex7seg
  import seg_pkg::*;
(
  input  logic [3:0] i_nib,
  output logic [6:0] o_seg
);
  assign o_seg = HEX7SEG[i_nib];
endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: 4-digit common-anode seven-segment scan controller.
// Cycles the anodes over one shared cathode bus and double-buffers the
// displayed value so updates only land at the digit-3 -> digit-0 wrap.
//   clk, rst_n : clock, async active-low reset
//   bus        : seg_scan_ctrl_if.slave (en/load/value/dp/blank in,
//                seg/an/frame out, all outputs registered)
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int SCAN_DIV = 100000,
  parameter int GUARD    = 2,
  parameter int LZB      = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  seg_scan_ctrl_if.slave bus
);
  localparam int CW = $clog2(SCAN_DIV);

  logic [CW-1:0] r_cnt;
  dig_t          r_dig;
  disp_buf_t     r_act, r_pend;
  logic          r_dirty;
  logic [3:0]    r_an;
  logic [7:0]    r_seg;
  logic          r_frame;

  logic          w_tick, w_commit, w_dig_on;
  logic [3:0]    w_nib;
  logic [6:0]    w_seg7;

  assign w_tick   = (r_cnt == CW'(SCAN_DIV - 1));
  // Commit only on the wrap out of digit 3 so a frame never mixes buffers.
  assign w_commit = w_tick && (r_dig == 2'd3) && r_dirty;
  assign w_nib    = 4'(r_act.value >> {r_dig, 2'b00});

  // Guard cycles at slot start keep the previous digit's cathodes from
  // ghosting onto the newly selected anode.
  assign w_dig_on = bus.en
                 && (r_cnt >= CW'(GUARD))
                 && !r_act.blank[r_dig]
                 && !((LZB != 0) && lzb_off(r_act.value, r_dig));

  hex7seg u_dec (.i_nib(w_nib), .o_seg(w_seg7));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_dig   <= '0;
      r_act   <= '0;
      r_pend  <= '0;
      r_dirty <= 1'b0;
      r_an    <= AN_OFF;
      r_seg   <= SEG_OFF;
      r_frame <= 1'b0;
    end else begin
      r_cnt   <= w_tick ? '0 : r_cnt + 1'b1;
      r_frame <= w_commit;
      if (w_tick)   r_dig <= r_dig + 2'd1;
      if (w_commit) r_act <= r_pend;
      if (bus.load) r_pend <= '{value: bus.value, dp: bus.dp, blank: bus.blank};
      // A load coinciding with a commit keeps dirty set: that data goes next frame.
      if (bus.load)      r_dirty <= 1'b1;
      else if (w_commit) r_dirty <= 1'b0;
      r_an  <= w_dig_on ? ~(4'b0001 << r_dig) : AN_OFF;
      r_seg <= w_dig_on ? {~r_act.dp[r_dig], w_seg7} : SEG_OFF;
    end
  end

  assign bus.an    = r_an;
  assign bus.seg   = r_seg;
  assign bus.frame = r_frame;
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl (SCAN_DIV=4, GUARD=1). u_dut0 runs with
// leading-zero blanking, u_dut1 without; both see the same inputs.
// cyc counts rising edges since reset release; at the falling edge where
// cyc==n the pins show the scan state of cycle n-1 (cnt=(n-1)%4,
// dig=((n-1)/4)%4).
module tb_seg_scan_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b1, load = 1'b0;
  logic [15:0] value = '0;
  logic [3:0]  dp = '0, blank = '0;
  int          cyc;
  int          n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n)
    if (!rst_n) cyc <= 0; else cyc <= cyc + 1;

  seg_scan_ctrl_if u_if0 ();
  seg_scan_ctrl_if u_if1 ();
  assign u_if0.en = en;  assign u_if0.load = load;  assign u_if0.value = value;
  assign u_if0.dp = dp;  assign u_if0.blank = blank;
  assign u_if1.en = en;  assign u_if1.load = load;  assign u_if1.value = value;
  assign u_if1.dp = dp;  assign u_if1.blank = blank;

  seg_scan_ctrl #(.SCAN_DIV(4), .GUARD(1), .LZB(1)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .bus(u_if0.slave));
  seg_scan_ctrl #(.SCAN_DIV(4), .GUARD(1), .LZB(0)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .bus(u_if1.slave));

  localparam logic [3:0] AN_SEL [4] = '{4'hE, 4'hD, 4'hB, 4'h7};

  task automatic wait_cyc(input int n);
    int k = 0;
    while (cyc != n && k < 1000) begin @(negedge clk); k++; end
    if (cyc != n) begin
      n_chk++; n_fail++;
      $display("FAIL wait_cyc: cyc=%0d required %0d", cyc, n);
    end
  endtask

  task automatic test_reset();
    logic [3:0] ea; logic [7:0] es;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_chk += 3;
    if (u_if0.an !== 4'hF)    begin n_fail++; $display("FAIL rst_an: got %h want F", u_if0.an); end
    if (u_if0.seg !== 8'hFF)  begin n_fail++; $display("FAIL rst_seg: got %h want FF", u_if0.seg); end
    if (u_if0.frame !== 1'b0) begin n_fail++; $display("FAIL rst_frame: got %b want 0", u_if0.frame); end
    rst_n = 1'b1;
    for (int n = 1; n <= 16; n++) begin
      @(negedge clk);
      ea = (n >= 2 && n <= 4) ? 4'hE : 4'hF;
      es = (n >= 2 && n <= 4) ? 8'hC0 : 8'hFF;
      n_chk += 3;
      if (u_if0.an !== ea)      begin n_fail++; $display("FAIL idle_an cyc %0d: got %h want %h", n, u_if0.an, ea); end
      if (u_if0.seg !== es)     begin n_fail++; $display("FAIL idle_seg cyc %0d: got %h want %h", n, u_if0.seg, es); end
      if (u_if0.frame !== 1'b0) begin n_fail++; $display("FAIL idle_frame cyc %0d: got %b want 0", n, u_if0.frame); end
    end
  endtask

  task automatic test_load_12af();
    logic [7:0] sg [4] = '{8'h8E, 8'h88, 8'hA4, 8'hF9};
    int s, c, d;
    wait_cyc(18);
    value = 16'h12AF; load = 1'b1;
    @(negedge clk); load = 1'b0;
    for (int n = 19; n <= 48; n++) begin
      s = n - 1; c = s % 4; d = (s / 4) % 4;
      n_chk++;
      if (u_if0.frame !== (n == 32)) begin n_fail++; $display("FAIL f12af_frame cyc %0d: got %b want %b", n, u_if0.frame, n == 32); end
      if (n >= 33) begin
        n_chk += 2;
        if (u_if0.an !== (c == 0 ? 4'hF : AN_SEL[d]))
          begin n_fail++; $display("FAIL f12af_an cyc %0d: got %h want %h", n, u_if0.an, c == 0 ? 4'hF : AN_SEL[d]); end
        if (u_if0.seg !== (c == 0 ? 8'hFF : sg[d]))
          begin n_fail++; $display("FAIL f12af_seg cyc %0d: got %h want %h", n, u_if0.seg, c == 0 ? 8'hFF : sg[d]); end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_lzb();
    logic [3:0] a0 [4] = '{4'hE, 4'hD, 4'hF, 4'hF};
    logic [7:0] s0 [4] = '{8'hC0, 8'h92, 8'hFF, 8'hFF};
    logic [7:0] s1 [4] = '{8'hC0, 8'h92, 8'hC0, 8'hC0};
    int s, c, d;
    wait_cyc(50);
    value = 16'h0050; load = 1'b1;
    @(negedge clk); load = 1'b0;
    for (int n = 51; n <= 80; n++) begin
      s = n - 1; c = s % 4; d = (s / 4) % 4;
      n_chk++;
      if (u_if0.frame !== (n == 64)) begin n_fail++; $display("FAIL lzb_frame cyc %0d: got %b want %b", n, u_if0.frame, n == 64); end
      if (n >= 65) begin
        n_chk += 4;
        if (u_if0.an !== (c == 0 ? 4'hF : a0[d]))
          begin n_fail++; $display("FAIL lzb_an cyc %0d: got %h want %h", n, u_if0.an, c == 0 ? 4'hF : a0[d]); end
        if (u_if0.seg !== (c == 0 ? 8'hFF : s0[d]))
          begin n_fail++; $display("FAIL lzb_seg cyc %0d: got %h want %h", n, u_if0.seg, c == 0 ? 8'hFF : s0[d]); end
        if (u_if1.an !== (c == 0 ? 4'hF : AN_SEL[d]))
          begin n_fail++; $display("FAIL nolzb_an cyc %0d: got %h want %h", n, u_if1.an, c == 0 ? 4'hF : AN_SEL[d]); end
        if (u_if1.seg !== (c == 0 ? 8'hFF : s1[d]))
          begin n_fail++; $display("FAIL nolzb_seg cyc %0d: got %h want %h", n, u_if1.seg, c == 0 ? 8'hFF : s1[d]); end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    int s, c, d;
    logic [7:0] es;
    wait_cyc(82);
    value = 16'h1111; load = 1'b1;
    @(negedge clk); load = 1'b0;
    wait_cyc(86);
    value = 16'h2222; load = 1'b1;
    @(negedge clk); load = 1'b0;
    for (int n = 87; n <= 144; n++) begin
      s = n - 1; c = s % 4; d = (s / 4) % 4;
      n_chk++;
      if (u_if0.frame !== (n == 96 || n == 112 || n == 128))
        begin n_fail++; $display("FAIL b2b_frame cyc %0d: got %b", n, u_if0.frame); end
      if (n >= 97) begin
        // 2222 for one frame, then 4444, then 3333 (loaded on the commit cycle)
        es = (n <= 112) ? 8'hA4 : (n <= 128) ? 8'h99 : 8'hB0;
        if (c == 0) es = 8'hFF;
        n_chk += 2;
        if (u_if0.an !== (c == 0 ? 4'hF : AN_SEL[d]))
          begin n_fail++; $display("FAIL b2b_an cyc %0d: got %h want %h", n, u_if0.an, c == 0 ? 4'hF : AN_SEL[d]); end
        if (u_if0.seg !== es)
          begin n_fail++; $display("FAIL b2b_seg cyc %0d: got %h want %h", n, u_if0.seg, es); end
      end
      load  = (n == 100 || n == 111);
      value = (n == 111) ? 16'h3333 : 16'h4444;
      @(negedge clk);
      load = 1'b0;
    end
  endtask

  task automatic test_blank_dp_en();
    logic [7:0] sg [4] = '{8'h00, 8'hFF, 8'h80, 8'h80};
    int s, c, d;
    logic off;
    wait_cyc(146);
    value = 16'h8888; dp = 4'b0001; blank = 4'b0010; load = 1'b1;
    @(negedge clk); load = 1'b0;
    for (int n = 147; n <= 192; n++) begin
      s = n - 1; c = s % 4; d = (s / 4) % 4;
      n_chk++;
      if (u_if0.frame !== (n == 160)) begin n_fail++; $display("FAIL bdp_frame cyc %0d: got %b want %b", n, u_if0.frame, n == 160); end
      if (n >= 161) begin
        off = (c == 0) || (d == 1) || (s == 184) || (s == 185);
        n_chk += 2;
        if (u_if0.an !== (off ? 4'hF : AN_SEL[d]))
          begin n_fail++; $display("FAIL bdp_an cyc %0d: got %h want %h", n, u_if0.an, off ? 4'hF : AN_SEL[d]); end
        if (u_if0.seg !== (off ? 8'hFF : sg[d]))
          begin n_fail++; $display("FAIL bdp_seg cyc %0d: got %h want %h", n, u_if0.seg, off ? 8'hFF : sg[d]); end
      end
      en = !(n == 184 || n == 185);
      @(negedge clk);
    end
    en = 1'b1;
  endtask

  task automatic test_reset_mid();
    int s, c, d;
    logic [3:0] ea; logic [7:0] es;
    wait_cyc(202);
    n_chk += 2;
    if (u_if0.an !== 4'hB)   begin n_fail++; $display("FAIL mid_pre_an: got %h want B", u_if0.an); end
    if (u_if0.seg !== 8'h80) begin n_fail++; $display("FAIL mid_pre_seg: got %h want 80", u_if0.seg); end
    rst_n = 1'b0;
    #1;
    n_chk += 3;
    if (u_if0.an !== 4'hF)    begin n_fail++; $display("FAIL mid_rst_an: got %h want F", u_if0.an); end
    if (u_if0.seg !== 8'hFF)  begin n_fail++; $display("FAIL mid_rst_seg: got %h want FF", u_if0.seg); end
    if (u_if1.an !== 4'hF)    begin n_fail++; $display("FAIL mid_rst_an1: got %h want F", u_if1.an); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int n = 1; n <= 16; n++) begin
      @(negedge clk);
      s = n - 1; c = s % 4; d = (s / 4) % 4;
      ea = (n >= 2 && n <= 4) ? 4'hE : 4'hF;
      es = (n >= 2 && n <= 4) ? 8'hC0 : 8'hFF;
      n_chk += 4;
      if (u_if0.an !== ea)  begin n_fail++; $display("FAIL post_an cyc %0d: got %h want %h", n, u_if0.an, ea); end
      if (u_if0.seg !== es) begin n_fail++; $display("FAIL post_seg cyc %0d: got %h want %h", n, u_if0.seg, es); end
      if (u_if1.an !== (c == 0 ? 4'hF : AN_SEL[d]))
        begin n_fail++; $display("FAIL post_an1 cyc %0d: got %h want %h", n, u_if1.an, c == 0 ? 4'hF : AN_SEL[d]); end
      if (u_if1.seg !== (c == 0 ? 8'hFF : 8'hC0))
        begin n_fail++; $display("FAIL post_seg1 cyc %0d: got %h want %h", n, u_if1.seg, c == 0 ? 8'hFF : 8'hC0); end
    end
  endtask

  initial begin
    test_reset();
    test_load_12af();
    test_lzb();
    test_back_to_back();
    test_blank_dp_en();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/seg_scan_ctrl.md
# seg_scan_ctrl

Time-multiplexing controller for the 4-digit, common-anode seven-segment display on the board. It shares the single active-low segment bus among the four digits by cycling the anodes. It double-buffers a 16-bit hex value so new data commits only at frame boundaries, so the display never shows a torn value. It sits between the counter/button datapath and the top-level `seg`/`an` pins.

## Interface
- `SCAN_DIV`, default 100000: clock cycles per digit slot, ≥ `GUARD`+2. 1 kHz per digit at 100 MHz.
- `GUARD`, default 2: cycles at the start of each slot with all anodes off, for anti-ghosting.
- `LZB`, default 1: leading-zero blanking enable.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `en`  in  1  display enable; 0 forces `an`=4'hF while scanning continues.
- `load`  in  1  one-cycle strobe that captures `value`, `dp`, `blank` into the pending buffer.
- `value`  in  16  four hex nibbles; nibble k drives digit k (digit 0 is rightmost).
- `dp`  in  4  decimal point per digit, 1 = lit.
- `blank`  in  4  forced blank per digit, 1 = off.
- `seg`  out  8  active-low cathodes: [0]=CA … [6]=CG, [7]=DP.
- `an`  out  4  active-low anodes, one-hot or all-off.
- `frame`  out  1  one-cycle pulse when the pending buffer commits to the active buffer.

## Operation
- Slot counter `cnt` runs 0..`SCAN_DIV`-1 and wraps. `tick` = (`cnt`==`SCAN_DIV`-1).
- Digit index `dig` (2 bits) advances on `tick` through 0→1→2→3→0.
- Pending buffer: on `load`, it captures the inputs. A later `load` overwrites it; last load wins.
- Pending dirty flag: set by `load`, cleared on commit. If `load` and commit occur in the same cycle, the flag ends set. The freshly captured data commits at the next frame.
- Commit happens on `tick` while `dig`==3 and dirty=1, i.e. the wrap to digit 0. Pending copies to active and `frame` pulses in that cycle.
- Per-slot digit enable:
  - off if `blank[dig]`;
  - off if `LZB`=1, `dig`≠0, and all active nibbles at index ≥ `dig` are zero;
  - off if `cnt` < `GUARD` or `en`=0.
- Digit 0 is never suppressed by LZB.
- Segment data: hex decode of active nibble `dig`, with DP cleared (lit) when active `dp[dig]`=1.
- Decode (active-low, DP off): 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90, A=88, b=83, C=C6, d=A1, E=86, F=8E.
- `an` = ~(1<<`dig`) when the digit is enabled, else 4'hF. `seg` = 8'hFF whenever `an`=4'hF.

## Timing
- Reset values: `cnt`=0, `dig`=0, active and pending buffers = 0 (value 0, dp 0, blank 0), dirty=0, `an`=4'hF, `seg`=8'hFF, `frame`=0.
- `an` and `seg` are registered: one cycle of latency from `cnt`/`dig` state to pins.
- After reset release with `GUARD`=g, digit 0 first lights at cycle g+1, showing `an`=4'b1110, `seg`=8'hC0.
- `load` → display latency: up to one full frame (4·`SCAN_DIV` cycles) plus 1.
- `frame` is registered; it is high in the cycle after the commit edge, together with the first guard cycle of digit 0.
- Reset asserted mid-frame clears everything immediately; outputs go off asynchronously.
- `en` takes effect on the next registered output, with no change to scan phase.

## Structure
- Package `seg_pkg`:
  - the 16-entry `HEX7SEG` constant;
  - `SEG_OFF`=8'hFF and `AN_OFF`=4'hF;
  - digit-index typedef (2-bit).
- Sub-module `hex7seg`: combinational nibble→7-bit decoder, reused by other display blocks.
- Top: counter, digit FSM, two buffers, LZB logic, output registers.

## Test plan
All scenarios use `SCAN_DIV`=4, `GUARD`=1, `LZB`=1 unless stated.
- Reset then idle → `an`=4'hF/`seg`=FF during reset. After release: 1 guard cycle off, then `an`=1110, `seg`=C0 for 3 cycles. Digits 1–3 stay off (LZB, value 0).
- `load` with `value`=16'h12AF, `dp`=0, `blank`=0 at mid-frame → `frame` pulses once at the next wrap. Then it scans F(8E)/1110, A(88)/1101, 2(A4)/1011, 1(F9)/0111, each slot with 1 guard-off cycle.
- `load` with `value`=16'h0050 → digits 3 and 2 blanked. Digit 1 shows 92, digit 0 shows C0. With `LZB`=0, all four lit.
- Two `load`s in one frame (16'h1111 then 16'h2222) → only 2222 ever appears, with one `frame` pulse. `load` on the commit cycle → that data appears one frame later.
- `blank`=4'b0010 and `dp`=4'b0001 with `value`=16'h8888 → digit 1 off. Digit 0 `seg`=00 (DP lit). Toggling `en`=0 forces `an`=F without shifting slot phase.
- Assert `rst_n`=0 during digit 2 → `an`/`seg` go F/FF at once and the buffers clear. Scanning restarts at digit 0 showing 0.
